// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: width helper and arbiter state encoding.
package fifo_pkg;

  // Ceiling log2, never less than 1 so single-entry indices still get a bit.
  function automatic int unsigned clog2(int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port signals shared by the write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_data;

  // Environment side: requesters and the FIFO full flag.
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_data
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching circularly after last_idx_i.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [IDX_W-1:0] next_idx_o,
  output logic             any_req_o
);

  int unsigned cand;

  // Walk from farthest to nearest so the nearest set bit wins.
  always_comb begin
    next_idx_o = last_idx_i;
    cand       = 0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(last_idx_i) + i) % NREQ;
      if (req_i[cand]) next_idx_o = IDX_W'(cand);
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the asynchronous FIFO write port among NREQ burst requesters.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     wrclk,
  input  logic                     rst_n,
  fifo_wr_arbiter_if.slave         bus,
  output logic [clog2(NREQ)-1:0]   grant_idx,
  output logic                     busy,
  output logic [CNT_W-1:0]         wr_count
);

  localparam int unsigned IdxW  = clog2(NREQ);
  localparam int unsigned BeatW = clog2(BURST_MAX + 1);

  arb_state_e       state_q;
  logic [IdxW-1:0]  grant_q;
  logic [BeatW-1:0] beat_cnt_q;
  logic [CNT_W-1:0] count_q;

  logic [IdxW-1:0]  next_idx;
  logic             any_req;
  logic             g_valid;
  logic             g_last;
  logic             beat;
  logic             burst_done;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IdxW)
  ) u_rr_pick (
    .req_i      (bus.req_valid),
    .last_idx_i (grant_q),
    .next_idx_o (next_idx),
    .any_req_o  (any_req)
  );

  assign g_valid    = bus.req_valid[grant_q];
  assign g_last     = bus.req_last[grant_q];
  assign beat       = (state_q == StGrant) & g_valid & ~bus.fifo_full;
  assign burst_done = (beat_cnt_q == BeatW'(BURST_MAX - 1));

  // Ready is gated by full, so a write can never be issued into a full FIFO.
  always_comb begin
    bus.req_ready = '0;
    bus.fifo_data = '0;
    if (state_q == StGrant) bus.req_ready[grant_q] = ~bus.fifo_full;
    if (beat) bus.fifo_data = bus.req_data[grant_q*WIDTH +: WIDTH];
  end

  assign bus.fifo_wr = beat;

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= IdxW'(NREQ - 1);
      beat_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q    <= next_idx;
            beat_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (beat) begin
            count_q    <= count_q + 1'b1;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (g_last || burst_done) state_q <= StIdle;
          end else if (!bus.fifo_full && !g_valid) begin
            // Requester walked away from its grant; backpressure alone never releases.
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == StGrant);
  assign wr_count  = count_q;

endmodule
